pipeline_run_ctrl: RTL and testbench
====================================

Name: pipeline_run_ctrl

Overview:
Run/halt sequencer for the 5-stage pipelined CPU. It starts the core from PC 0, detects the halt instruction (all-zero word) or an external halt request in IF, and stops fetch. It then drains the instructions already in flight and raises `halted`. It also keeps the cycle and retired-instruction counters that benches and the debug path read for execution-time reporting.

Parameters:
- DRAIN_CYCLES, 4, cycles fetch stays off after halt detection so ID/EX/MEM/WB empty (min 1)
- CNT_WIDTH, 32, width of cycle_count and retire_count
- HALT_INSTR, 32'h0000_0000, instruction word treated as halt
- WDOG_LIMIT, 100000, cycle_count value that trips the watchdog (only with WATCHDOG_EN)

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin execution; honoured only in IDLE or HALTED
- halt_req  in  1  external halt request; honoured only in RUN
- if_valid  in  1  IF stage holds a valid fetched word
- if_instr  in  32  instruction word in IF
- wb_valid  in  1  an instruction retires in WB this cycle
- fetch_en  out  1  PC update and IF fetch enable
- pc_clear  out  1  one-cycle pulse forcing PC to 0
- pipe_flush  out  1  one-cycle pulse clearing all pipeline registers to bubbles
- kill_if  out  1  squash the IF word (halt word never enters ID)
- running  out  1  state is RUN or DRAIN
- halted  out  1  state is HALTED
- halt_cause  out  2  0 none, 1 halt instruction, 2 halt_req, 3 watchdog
- cycle_count  out  CNT_WIDTH  cycles spent in RUN+DRAIN since last start
- retire_count  out  CNT_WIDTH  wb_valid cycles in RUN+DRAIN since last start

Behaviour:
- States: IDLE, RUN, DRAIN, HALTED.
- Reset state is IDLE. Reset values: all outputs 0. Counters 0, drain counter 0, flush-pending flag 0.
- reset_n low at any time, including mid-RUN or mid-DRAIN: immediate return to IDLE with reset values. No partial counts are kept.

IDLE:
- All outputs 0.
- start=1 → RUN. Counters cleared to 0 and the flush-pending flag is set at the same edge.

First RUN cycle (flush cycle):
- pc_clear=1, pipe_flush=1, fetch_en=0.
- Halt detection is suppressed in this cycle.
- Flag clears at the next edge.

Later RUN cycles:
- fetch_en=1.
- kill_if is combinational: `kill_if = if_valid & (if_instr==HALT_INSTR)`.

RUN → DRAIN at the edge where either condition holds:
- if_valid & if_instr==HALT_INSTR → halt_cause=1.
- Otherwise, halt_req=1 → halt_cause=2.
- Both in the same cycle → cause 1 (halt instruction has priority).
- On entry, the drain counter loads DRAIN_CYCLES-1.

DRAIN:
- fetch_en=0, kill_if=0.
- Each edge: if the counter is 0 → HALTED, else decrement.
- DRAIN therefore lasts exactly DRAIN_CYCLES cycles.

HALTED:
- halted=1; counters and halt_cause frozen.
- start=1 → RUN with the same sequence as from IDLE. halt_cause returns to 0 on that edge.

Counters:
- cycle_count increments on every edge where the state is RUN or DRAIN, including the flush cycle.
- retire_count increments on edges where the state is RUN or DRAIN and wb_valid=1.
- Both saturate at all-ones and never wrap.

Ignored inputs:
- start in RUN or DRAIN.
- halt_req in IDLE, DRAIN or HALTED. A halt_req still asserted when RUN is re-entered is honoured from the second RUN cycle.

Output timing:
- All outputs are registered except kill_if and fetch_en, which decode the current state.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined: in RUN (not the flush cycle), if cycle_count ≥ WDOG_LIMIT-1 at an edge → DRAIN with halt_cause=3. A halt instruction or halt_req in that same cycle wins, with causes 1/2 as above.
- Not defined: no watchdog logic; halt_cause never equals 3; WDOG_LIMIT is unused.

Test Plan:
1. DRAIN_CYCLES=4: start at cycle 0; halt word at if_instr in RUN cycle 6; wb_valid=1 in cycles 3,4,5 → kill_if=1 only in cycle 6; halted rises after 4 DRAIN cycles; cycle_count=10, retire_count=3, halt_cause=1.
2. halt_req and halt word asserted together in RUN cycle 3 → halt_cause=1; cycle_count=3+DRAIN_CYCLES at halt.
3. Halt word presented in the flush cycle → ignored, fetch_en=1 next cycle; halt_req in cycle 5 → halt_cause=2, cycle_count=9.
4. reset_n low in DRAIN cycle 2 → outputs 0 asynchronously, state IDLE. start after release → pc_clear and pipe_flush pulse for exactly 1 cycle, counters restart from 0.
5. From HALTED (cycle_count=10): start → counters clear, halt_cause=0, running=1. start held during RUN → no second flush pulse.
6. WATCHDOG_EN, WDOG_LIMIT=20, no halt word → DRAIN entered at cycle_count=20, halt_cause=3, halted with cycle_count=24. Without the macro, same stimulus stays in RUN indefinitely.

Source files
------------

// File: rtl/pipeline_run_ctrl.sv
// Run/halt sequencer for the 5-stage core: flush-start, halt detection, drain, cycle/retire counters.
// Optional watchdog halt is compiled in with `define WATCHDOG_EN.
module pipeline_run_ctrl #(
  parameter int          DRAIN_CYCLES = 4,
  parameter int          CNT_WIDTH    = 32,
  parameter logic [31:0] HALT_INSTR   = 32'h0000_0000,
  parameter int          WDOG_LIMIT   = 100000
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic                 halt_req_i,
  input  logic                 if_valid_i,
  input  logic [31:0]          if_instr_i,
  input  logic                 wb_valid_i,
  output logic                 fetch_en_o,
  output logic                 pc_clear_o,
  output logic                 pipe_flush_o,
  output logic                 kill_if_o,
  output logic                 running_o,
  output logic                 halted_o,
  output logic [1:0]           halt_cause_o,
  output logic [CNT_WIDTH-1:0] cycle_count_o,
  output logic [CNT_WIDTH-1:0] retire_count_o
);

  // state   | meaning
  // IDLE    | out of reset, nothing fetched
  // RUN     | executing; first cycle is the flush cycle (flush_q=1)
  // DRAIN   | fetch off, in-flight instructions retire
  // HALTED  | stopped, counters and cause frozen
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [1:0]           state_q, state_d;
  logic                 flush_q, flush_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] retire_q, retire_d;
  logic                 running_q, halted_q;
  logic                 halt_word;
  logic                 run_live;

  assign halt_word = if_valid_i && (if_instr_i == HALT_INSTR);
  assign run_live  = (state_q == S_RUN) && !flush_q;

`ifdef WATCHDOG_EN
  logic wdog_hit;
  assign wdog_hit = (cycle_q >= CNT_WIDTH'(WDOG_LIMIT - 1));
`endif

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    drain_d  = drain_q;
    cause_d  = cause_q;
    cycle_d  = cycle_q;
    retire_d = retire_q;

    // counters saturate rather than wrap
    if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
      if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
      if (wb_valid_i && (retire_q != '1)) retire_d = retire_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_i) begin
          state_d  = S_RUN;
          flush_d  = 1'b1;
          cycle_d  = '0;
          retire_d = '0;
          cause_d  = 2'd0;
        end
      end
      S_RUN: begin
        flush_d = 1'b0;
        if (!flush_q) begin
          if (halt_word) begin
            state_d = S_DRAIN;
            cause_d = 2'd1;
            drain_d = DW'(DRAIN_CYCLES - 1);
          end else if (halt_req_i) begin
            state_d = S_DRAIN;
            cause_d = 2'd2;
            drain_d = DW'(DRAIN_CYCLES - 1);
          end
`ifdef WATCHDOG_EN
          else if (wdog_hit) begin
            state_d = S_DRAIN;
            cause_d = 2'd3;
            drain_d = DW'(DRAIN_CYCLES - 1);
          end
`endif
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_HALTED;
        else               drain_d = drain_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      flush_q   <= 1'b0;
      drain_q   <= '0;
      cause_q   <= 2'd0;
      cycle_q   <= '0;
      retire_q  <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      drain_q   <= drain_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
      running_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
      halted_q  <= (state_d == S_HALTED);
    end
  end

  // halt word is squashed in IF so it never reaches ID
  assign fetch_en_o     = run_live;
  assign kill_if_o      = run_live && halt_word;
  assign pc_clear_o     = flush_q;
  assign pipe_flush_o   = flush_q;
  assign running_o      = running_q;
  assign halted_o       = halted_q;
  assign halt_cause_o   = cause_q;
  assign cycle_count_o  = cycle_q;
  assign retire_count_o = retire_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Scenario bench for pipeline_run_ctrl: expected halt results are queued at stimulus time
// and compared once the controller reports halted.
module tb_pipeline_run_ctrl;
  localparam int DC = 4;

  logic        clk_i = 1'b0;
  logic        reset_n_i, start_i, halt_req_i, if_valid_i, wb_valid_i;
  logic [31:0] if_instr_i;
  logic        fetch_en_o, pc_clear_o, pipe_flush_o, kill_if_o, running_o, halted_o;
  logic [1:0]  halt_cause_o;
  logic [31:0] cycle_count_o, retire_count_o;

  typedef struct {
    int unsigned cyc;
    int unsigned ret;
    int unsigned cause;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   ok;

  always #5 clk_i = ~clk_i;

  pipeline_run_ctrl #(
    .DRAIN_CYCLES(DC), .CNT_WIDTH(32), .HALT_INSTR(32'h0000_0000), .WDOG_LIMIT(20)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .halt_req_i(halt_req_i),
    .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .wb_valid_i(wb_valid_i),
    .fetch_en_o(fetch_en_o), .pc_clear_o(pc_clear_o), .pipe_flush_o(pipe_flush_o),
    .kill_if_o(kill_if_o), .running_o(running_o), .halted_o(halted_o),
    .halt_cause_o(halt_cause_o), .cycle_count_o(cycle_count_o), .retire_count_o(retire_count_o)
  );

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clr_in();
    start_i = 0; halt_req_i = 0; if_valid_i = 0; if_instr_i = 32'h13; wb_valid_i = 0;
  endtask

  task automatic wait_halted(output bit done);
    int n = 0;
    done = 0;
    while (!halted_o && n < 100) begin
      step();
      n++;
    end
    #1;
    done = halted_o;
  endtask

  task automatic test_reset();
    clr_in();
    reset_n_i = 1;
    #1 reset_n_i = 0;
    #1;
    checks++;
    if (fetch_en_o !== 0 || pc_clear_o !== 0 || pipe_flush_o !== 0 || kill_if_o !== 0 ||
        running_o !== 0 || halted_o !== 0 || halt_cause_o !== 0 || cycle_count_o !== 0 ||
        retire_count_o !== 0) begin
      errors++;
      $display("FAIL reset_outputs: fe=%b pc=%b fl=%b k=%b r=%b h=%b c=%0d cyc=%0d ret=%0d expected all 0",
               fetch_en_o, pc_clear_o, pipe_flush_o, kill_if_o, running_o, halted_o,
               halt_cause_o, cycle_count_o, retire_count_o);
    end
    step(); step();
    reset_n_i = 1;
    halt_req_i = 1; if_valid_i = 1; if_instr_i = 32'h0;
    step(); step();
    #1;
    checks++;
    if (running_o !== 0 || halted_o !== 0 || kill_if_o !== 0 || fetch_en_o !== 0 || halt_cause_o !== 0) begin
      errors++;
      $display("FAIL idle_ignores_halt: r=%b h=%b k=%b fe=%b c=%0d expected 0 0 0 0 0",
               running_o, halted_o, kill_if_o, fetch_en_o, halt_cause_o);
    end
    clr_in();
  endtask

  task automatic test_halt_instr();
    start_i = 1; step(); start_i = 0;
    sb_q.push_back('{10, 3, 1});
    for (int c = 1; c <= 6; c++) begin
      wb_valid_i = (c >= 3 && c <= 5);
      if_valid_i = 1;
      if_instr_i = (c == 6) ? 32'h0 : 32'h13 + c;
      #1;
      checks++;
      if (kill_if_o !== (c == 6)) begin
        errors++;
        $display("FAIL kill_if_c%0d: got %b expected %b", c, kill_if_o, (c == 6));
      end
      if (c == 1) begin
        checks++;
        if ({pc_clear_o, pipe_flush_o, fetch_en_o, running_o} !== 4'b1101) begin
          errors++;
          $display("FAIL flush_cycle: pc/fl/fe/run=%b expected 1101",
                   {pc_clear_o, pipe_flush_o, fetch_en_o, running_o});
        end
      end else if (c == 2) begin
        checks++;
        if ({pc_clear_o, pipe_flush_o, fetch_en_o, running_o} !== 4'b0011) begin
          errors++;
          $display("FAIL run_cycle2: pc/fl/fe/run=%b expected 0011",
                   {pc_clear_o, pipe_flush_o, fetch_en_o, running_o});
        end
      end
      step();
    end
    wb_valid_i = 0;
    for (int c = 7; c <= 10; c++) begin
      #1;
      checks++;
      if (fetch_en_o !== 0 || kill_if_o !== 0 || running_o !== 1 || halted_o !== 0 || halt_cause_o !== 1) begin
        errors++;
        $display("FAIL drain_c%0d: fe=%b k=%b r=%b h=%b cause=%0d expected 0 0 1 0 1",
                 c, fetch_en_o, kill_if_o, running_o, halted_o, halt_cause_o);
      end
      step();
    end
    #1;
    checks++;
    if (halted_o !== 1 || running_o !== 0) begin
      errors++;
      $display("FAIL halt_after_drain: halted=%b running=%b expected 1 0", halted_o, running_o);
    end
    e = sb_q.pop_front();
    checks++;
    if (cycle_count_o !== e.cyc || retire_count_o !== e.ret || halt_cause_o !== e.cause) begin
      errors++;
      $display("FAIL halt_instr_result: cyc=%0d ret=%0d cause=%0d expected %0d %0d %0d",
               cycle_count_o, retire_count_o, halt_cause_o, e.cyc, e.ret, e.cause);
    end
    clr_in();
    step(); step();
    #1;
    checks++;
    if (cycle_count_o !== 10 || halted_o !== 1) begin
      errors++;
      $display("FAIL halted_frozen: cyc=%0d halted=%b expected 10 1", cycle_count_o, halted_o);
    end
  endtask

  task automatic test_restart();
    start_i = 1; step();
    #1;
    checks++;
    if (cycle_count_o !== 0 || retire_count_o !== 0 || halt_cause_o !== 0 ||
        {pc_clear_o, pipe_flush_o, running_o, halted_o} !== 4'b1110) begin
      errors++;
      $display("FAIL restart_flush: cyc=%0d ret=%0d cause=%0d pc/fl/run/h=%b expected 0 0 0 1110",
               cycle_count_o, retire_count_o, halt_cause_o, {pc_clear_o, pipe_flush_o, running_o, halted_o});
    end
    step();
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) begin
        halt_req_i = 1;
        sb_q.push_back('{8, 0, 2});
      end
      #1;
      checks++;
      if (pc_clear_o !== 0 || pipe_flush_o !== 0) begin
        errors++;
        $display("FAIL start_held_c%0d: pc=%b fl=%b expected 0 0", c, pc_clear_o, pipe_flush_o);
      end
      step();
    end
    clr_in();
    wait_halted(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_timeout: halted=%b expected 1", halted_o); end
    e = sb_q.pop_front();
    checks++;
    if (cycle_count_o !== e.cyc || retire_count_o !== e.ret || halt_cause_o !== e.cause) begin
      errors++;
      $display("FAIL restart_result: cyc=%0d ret=%0d cause=%0d expected %0d %0d %0d",
               cycle_count_o, retire_count_o, halt_cause_o, e.cyc, e.ret, e.cause);
    end
  endtask

  task automatic test_both();
    start_i = 1; step(); start_i = 0;
    step(); step();
    halt_req_i = 1; if_valid_i = 1; if_instr_i = 32'h0;
    sb_q.push_back('{3 + DC, 0, 1});
    step();
    clr_in();
    wait_halted(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL both_timeout: halted=%b expected 1", halted_o); end
    e = sb_q.pop_front();
    checks++;
    if (cycle_count_o !== e.cyc || retire_count_o !== e.ret || halt_cause_o !== e.cause) begin
      errors++;
      $display("FAIL both_result: cyc=%0d ret=%0d cause=%0d expected %0d %0d %0d",
               cycle_count_o, retire_count_o, halt_cause_o, e.cyc, e.ret, e.cause);
    end
  endtask

  task automatic test_flush_ignore();
    start_i = 1; step(); start_i = 0;
    if_valid_i = 1; if_instr_i = 32'h0;
    #1;
    checks++;
    if (kill_if_o !== 0) begin errors++; $display("FAIL flush_kill: got %b expected 0", kill_if_o); end
    step();
    if_valid_i = 0;
    #1;
    checks++;
    if (fetch_en_o !== 1 || running_o !== 1) begin
      errors++;
      $display("FAIL flush_ignored: fe=%b run=%b expected 1 1", fetch_en_o, running_o);
    end
    step(); step(); step();
    halt_req_i = 1;
    sb_q.push_back('{9, 2, 2});
    step();
    halt_req_i = 0; wb_valid_i = 1;
    step(); step();
    clr_in();
    wait_halted(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL req_timeout: halted=%b expected 1", halted_o); end
    e = sb_q.pop_front();
    checks++;
    if (cycle_count_o !== e.cyc || retire_count_o !== e.ret || halt_cause_o !== e.cause) begin
      errors++;
      $display("FAIL req_result: cyc=%0d ret=%0d cause=%0d expected %0d %0d %0d",
               cycle_count_o, retire_count_o, halt_cause_o, e.cyc, e.ret, e.cause);
    end
  endtask

  task automatic test_async_reset();
    start_i = 1; step(); start_i = 0;
    step(); step();
    halt_req_i = 1; step(); halt_req_i = 0;
    step();
    reset_n_i = 0;
    #1;
    checks++;
    if (running_o !== 0 || halted_o !== 0 || fetch_en_o !== 0 || halt_cause_o !== 0 ||
        cycle_count_o !== 0 || retire_count_o !== 0) begin
      errors++;
      $display("FAIL async_reset: r=%b h=%b fe=%b cause=%0d cyc=%0d ret=%0d expected all 0",
               running_o, halted_o, fetch_en_o, halt_cause_o, cycle_count_o, retire_count_o);
    end
    step(); step();
    reset_n_i = 1;
    step();
    #1;
    checks++;
    if (running_o !== 0 || halted_o !== 0 || cycle_count_o !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: r=%b h=%b cyc=%0d expected 0 0 0", running_o, halted_o, cycle_count_o);
    end
    start_i = 1; step(); start_i = 0;
    #1;
    checks++;
    if (pc_clear_o !== 1 || pipe_flush_o !== 1 || cycle_count_o !== 0 || retire_count_o !== 0) begin
      errors++;
      $display("FAIL reset_restart: pc=%b fl=%b cyc=%0d ret=%0d expected 1 1 0 0",
               pc_clear_o, pipe_flush_o, cycle_count_o, retire_count_o);
    end
    step();
    halt_req_i = 1;
    sb_q.push_back('{2 + DC, 0, 2});
    #1;
    checks++;
    if (pc_clear_o !== 0 || pipe_flush_o !== 0 || cycle_count_o !== 1) begin
      errors++;
      $display("FAIL pulse_width: pc=%b fl=%b cyc=%0d expected 0 0 1", pc_clear_o, pipe_flush_o, cycle_count_o);
    end
    step();
    clr_in();
    wait_halted(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_run_timeout: halted=%b expected 1", halted_o); end
    e = sb_q.pop_front();
    checks++;
    if (cycle_count_o !== e.cyc || retire_count_o !== e.ret || halt_cause_o !== e.cause) begin
      errors++;
      $display("FAIL reset_run_result: cyc=%0d ret=%0d cause=%0d expected %0d %0d %0d",
               cycle_count_o, retire_count_o, halt_cause_o, e.cyc, e.ret, e.cause);
    end
  endtask

  task automatic test_watchdog();
    start_i = 1; step(); start_i = 0;
    if_valid_i = 1; if_instr_i = 32'h33;
`ifdef WATCHDOG_EN
    sb_q.push_back('{20 + DC, 0, 3});
    for (int c = 1; c < 20; c++) step();
    #1;
    checks++;
    if (fetch_en_o !== 1) begin errors++; $display("FAIL wdog_c20: fe=%b expected 1", fetch_en_o); end
    step();
    #1;
    checks++;
    if (fetch_en_o !== 0 || running_o !== 1 || halt_cause_o !== 3 || cycle_count_o !== 20) begin
      errors++;
      $display("FAIL wdog_entry: fe=%b r=%b cause=%0d cyc=%0d expected 0 1 3 20",
               fetch_en_o, running_o, halt_cause_o, cycle_count_o);
    end
`else
    for (int c = 1; c <= 30; c++) step();
    #1;
    checks++;
    if (running_o !== 1 || fetch_en_o !== 1 || halted_o !== 0 || cycle_count_o !== 30) begin
      errors++;
      $display("FAIL no_wdog: r=%b fe=%b h=%b cyc=%0d expected 1 1 0 30",
               running_o, fetch_en_o, halted_o, cycle_count_o);
    end
    halt_req_i = 1;
    sb_q.push_back('{31 + DC, 0, 2});
    step();
`endif
    clr_in();
    wait_halted(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wdog_timeout: halted=%b expected 1", halted_o); end
    e = sb_q.pop_front();
    checks++;
    if (cycle_count_o !== e.cyc || retire_count_o !== e.ret || halt_cause_o !== e.cause) begin
      errors++;
      $display("FAIL wdog_result: cyc=%0d ret=%0d cause=%0d expected %0d %0d %0d",
               cycle_count_o, retire_count_o, halt_cause_o, e.cyc, e.ret, e.cause);
    end
  endtask

  initial begin
    test_reset();
    test_halt_instr();
    test_restart();
    test_both();
    test_flush_ignore();
    test_async_reset();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
